// File: rtl/mb_xfer_seq_if.sv
// Handshake bundle for the memory-buffer line-transfer sequencer.
//
// Groups the requester controls, the memory handshake and the MB/cache
// word strobes.
//   slave  : the sequencer's view (mb_xfer_seq).
//   master : the view of whatever drives the sequencer.
//
// Requester -> sequencer : start_h, mode_wr_h, start_adr_h, wd_req_h, abort_l
// Memory    -> sequencer : mem_ack_h, mem_data_val_h
// Sequencer -> requester : busy_h, done_h, err_empty_h
// Sequencer -> memory    : mem_rq_h, mem_wr_h
// Sequencer -> MB/cache  : mb_sel_h, mb_hold_in_h, csh_wr_en_h
interface mb_xfer_seq_if #(
    parameter int NWORDS = 4,
    parameter int SELW   = $clog2(NWORDS)
) ();
    logic              start_h;
    logic              mode_wr_h;
    logic [SELW-1:0]   start_adr_h;
    logic [NWORDS-1:0] wd_req_h;
    logic              mem_ack_h;
    logic              mem_data_val_h;
    logic              abort_l;
    logic              busy_h;
    logic [SELW-1:0]   mb_sel_h;
    logic [NWORDS-1:0] mb_hold_in_h;
    logic [NWORDS-1:0] csh_wr_en_h;
    logic              mem_rq_h;
    logic              mem_wr_h;
    logic              done_h;
    logic              err_empty_h;

    modport slave (
        input  start_h, mode_wr_h, start_adr_h, wd_req_h,
        input  mem_ack_h, mem_data_val_h, abort_l,
        output busy_h, mb_sel_h, mb_hold_in_h, csh_wr_en_h,
        output mem_rq_h, mem_wr_h, done_h, err_empty_h
    );

    modport master (
        output start_h, mode_wr_h, start_adr_h, wd_req_h,
        output mem_ack_h, mem_data_val_h, abort_l,
        input  busy_h, mb_sel_h, mb_hold_in_h, csh_wr_en_h,
        input  mem_rq_h, mem_wr_h, done_h, err_empty_h
    );
endinterface

// File: rtl/mb_xfer_seq.sv
// Memory-buffer line-transfer sequencer.
//
// Moves the requested words of one cache line between cache, memory buffer
// (MB) and memory.
//   Writeback : LOAD each requested word into the MB, then request a memory
//               write, then DONE.
//   Refill    : request a memory read, then strobe each returning word into
//               both MB and cache (XFER), then DONE.
// Words are visited in wrap order starting at start_adr_h, skipping words
// whose request bit is clear, one word per strobe cycle.
//
// Ports
//   clk_mbx_h  : clock, rising edge
//   mr_reset_l : asynchronous active-low reset
//   bus        : mb_xfer_seq_if.slave (controls, memory handshake, strobes)
module mb_xfer_seq #(
    parameter int NWORDS = 4,
    parameter int SELW   = $clog2(NWORDS)
) (
    input  logic          clk_mbx_h,
    input  logic          mr_reset_l,
    mb_xfer_seq_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOAD, REQ, XFER, DONE} state_t;

    state_t            state;
    logic [NWORDS-1:0] pending;     // words still to be handled
    logic [NWORDS-1:0] saved_mask;  // original mask, replayed for refill data
    logic [SELW-1:0]   ptr;         // where the wrap-order search begins
    logic [SELW-1:0]   saved_adr;
    logic [SELW-1:0]   sel_q;       // last word strobed; mb_sel_h holds it
    logic              mode_q;      // 1 = writeback
    logic              err_q;

    // Next pending word in wrap order ptr, ptr+1, ... Because NWORDS is a
    // power of two, SELW-bit addition wraps exactly at the line boundary.
    logic              found;
    logic [SELW-1:0]   next_idx;
    logic [SELW-1:0]   cand;
    logic [NWORDS-1:0] next_onehot;
    logic              last_word;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        found    = 1'b0;
        next_idx = ptr;
        cand     = '0;
        for (int i = 0; i < NWORDS; i++) begin
            cand = ptr + SELW'(i);
            if (!found && pending[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

    assign next_onehot = found ? (NWORDS'(1) << next_idx) : '0;
    assign last_word   = ((pending & ~next_onehot) == '0);

    // Strobes depend on this cycle's abort_l and mem_data_val_h, so an abort
    // or a data gap suppresses them in the very cycle it is seen.
    logic strobe_load;
    logic strobe_xfer;
    logic strobe;

    assign strobe_load = (state == LOAD) && bus.abort_l && found;
    assign strobe_xfer = (state == XFER) && bus.abort_l && bus.mem_data_val_h && found;
    assign strobe      = strobe_load || strobe_xfer;

    assign bus.mb_hold_in_h = strobe      ? next_onehot : '0;
    assign bus.csh_wr_en_h  = strobe_xfer ? next_onehot : '0;
    assign bus.mb_sel_h     = strobe      ? next_idx    : sel_q;

    assign bus.busy_h      = (state != IDLE);
    assign bus.mem_rq_h    = (state == REQ);
    assign bus.mem_wr_h    = (state == REQ) && mode_q;
    assign bus.done_h      = (state == DONE) && bus.abort_l;
    assign bus.err_empty_h = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_mbx_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            state      <= IDLE;
            pending    <= '0;
            saved_mask <= '0;
            ptr        <= '0;
            saved_adr  <= '0;
            sel_q      <= '0;
            mode_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (strobe) begin
                pending <= pending & ~next_onehot;
                ptr     <= next_idx + SELW'(1);
                sel_q   <= next_idx;
            end
            // Abort outranks mem_ack_h / mem_data_val_h in the same cycle.
            if (state != IDLE && !bus.abort_l) begin
                state   <= IDLE;
                pending <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start_h) begin
                            if (bus.wd_req_h != '0) begin
                                pending    <= bus.wd_req_h;
                                saved_mask <= bus.wd_req_h;
                                ptr        <= bus.start_adr_h;
                                saved_adr  <= bus.start_adr_h;
                                mode_q     <= bus.mode_wr_h;
                                state      <= bus.mode_wr_h ? LOAD : REQ;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (strobe_load && last_word) state <= REQ;
                    end
                    REQ: begin
                        if (bus.mem_ack_h) begin
                            if (mode_q) begin
                                state <= DONE;
                            end else begin
                                // Refill data comes back in the same order.
                                pending <= saved_mask;
                                ptr     <= saved_adr;
                                state   <= XFER;
                            end
                        end
                    end
                    XFER: begin
                        if (strobe_xfer && last_word) state <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mb_xfer_seq.sv
// Self-checking bench for mb_xfer_seq: a 4-word and an 8-word instance.
// Expected MB/cache strobes are queued when a transfer is started and
// compared whenever a DUT strobes; cycle-exact control outputs are checked
// inline.
module tb_mb_xfer_seq;

    typedef struct {
        int          sel;
        logic [15:0] hold;
        logic [15:0] csh;
    } exp_t;

    logic clk_mbx_h;
    logic mr_reset_l;

    int checks = 0;
    int errors = 0;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e4;
    exp_t e8;

    mb_xfer_seq_if #(.NWORDS(4)) bus4 ();
    mb_xfer_seq_if #(.NWORDS(8)) bus8 ();

    mb_xfer_seq #(.NWORDS(4)) dut4 (
        .clk_mbx_h  (clk_mbx_h),
        .mr_reset_l (mr_reset_l),
        .bus        (bus4)
    );

    mb_xfer_seq #(.NWORDS(8)) dut8 (
        .clk_mbx_h  (clk_mbx_h),
        .mr_reset_l (mr_reset_l),
        .bus        (bus8)
    );

    initial begin
        clk_mbx_h = 1'b0;
        forever #5 clk_mbx_h = ~clk_mbx_h;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_mbx_h);
        #1;
    endtask

    task automatic push4(input int idx, input bit wr);
        exp_t e;
        e.sel  = idx;
        e.hold = 16'(1) << idx;
        e.csh  = wr ? 16'h0 : e.hold;
        q4.push_back(e);
    endtask

    task automatic push8(input int idx, input bit wr);
        exp_t e;
        e.sel  = idx;
        e.hold = 16'(1) << idx;
        e.csh  = wr ? 16'h0 : e.hold;
        q8.push_back(e);
    endtask

    // Scoreboards: any nonzero strobe must match the next expected word.
    always @(negedge clk_mbx_h) begin
        if (bus4.mb_hold_in_h !== '0 || bus4.csh_wr_en_h !== '0) begin
            if (q4.size() == 0) begin
                check("sb4_unexpected_strobe", 32'(bus4.mb_hold_in_h), 32'h0);
            end else begin
                e4 = q4.pop_front();
                check("sb4_sel",  32'(bus4.mb_sel_h),     32'(e4.sel));
                check("sb4_hold", 32'(bus4.mb_hold_in_h), 32'(e4.hold));
                check("sb4_csh",  32'(bus4.csh_wr_en_h),  32'(e4.csh));
            end
        end
        if (bus8.mb_hold_in_h !== '0 || bus8.csh_wr_en_h !== '0) begin
            if (q8.size() == 0) begin
                check("sb8_unexpected_strobe", 32'(bus8.mb_hold_in_h), 32'h0);
            end else begin
                e8 = q8.pop_front();
                check("sb8_sel",  32'(bus8.mb_sel_h),     32'(e8.sel));
                check("sb8_hold", 32'(bus8.mb_hold_in_h), 32'(e8.hold));
                check("sb8_csh",  32'(bus8.csh_wr_en_h),  32'(e8.csh));
            end
        end
    end

    initial begin
        mr_reset_l = 1'b0;
        bus4.start_h = 0; bus4.mode_wr_h = 0; bus4.start_adr_h = '0; bus4.wd_req_h = '0;
        bus4.mem_ack_h = 0; bus4.mem_data_val_h = 0; bus4.abort_l = 1;
        bus8.start_h = 0; bus8.mode_wr_h = 0; bus8.start_adr_h = '0; bus8.wd_req_h = '0;
        bus8.mem_ack_h = 0; bus8.mem_data_val_h = 0; bus8.abort_l = 1;

        // Reset state
        tick(); tick();
        check("rst_busy",   32'(bus4.busy_h),       0);
        check("rst_sel",    32'(bus4.mb_sel_h),     0);
        check("rst_hold",   32'(bus4.mb_hold_in_h), 0);
        check("rst_mem_rq", 32'(bus4.mem_rq_h),     0);
        check("rst_done",   32'(bus4.done_h),       0);
        check("rst_err",    32'(bus4.err_empty_h),  0);
        check("rst_busy8",  32'(bus8.busy_h),       0);
        mr_reset_l = 1'b1;
        tick(); tick();

        // Writeback, start 2, mask 1111
        push4(2, 1); push4(3, 1); push4(0, 1); push4(1, 1);
        bus4.start_h = 1; bus4.mode_wr_h = 1; bus4.start_adr_h = 2; bus4.wd_req_h = 4'b1111;
        tick(); // cycle 1
        bus4.start_h = 0; bus4.wd_req_h = '0;
        check("wb_busy_c1",   32'(bus4.busy_h),   1);
        check("wb_sel_c1",    32'(bus4.mb_sel_h), 2);
        check("wb_mem_rq_c1", 32'(bus4.mem_rq_h), 0);
        tick(); tick(); tick(); // cycle 4
        check("wb_sel_c4",    32'(bus4.mb_sel_h), 1);
        check("wb_mem_rq_c4", 32'(bus4.mem_rq_h), 0);
        tick(); // cycle 5
        check("wb_mem_rq_c5", 32'(bus4.mem_rq_h),     1);
        check("wb_mem_wr_c5", 32'(bus4.mem_wr_h),     1);
        check("wb_hold_c5",   32'(bus4.mb_hold_in_h), 0);
        check("wb_sel_hold",  32'(bus4.mb_sel_h),     1);
        tick(); // cycle 6
        check("wb_mem_rq_c6", 32'(bus4.mem_rq_h), 1);
        tick(); // cycle 7
        bus4.mem_ack_h = 1;
        check("wb_done_c7", 32'(bus4.done_h), 0);
        tick(); // cycle 8
        bus4.mem_ack_h = 0;
        check("wb_done_c8",   32'(bus4.done_h),   1);
        check("wb_mem_rq_c8", 32'(bus4.mem_rq_h), 0);
        tick(); // cycle 9
        check("wb_busy_c9", 32'(bus4.busy_h), 0);
        check("wb_done_c9", 32'(bus4.done_h), 0);
        check("wb_q_empty", 32'(q4.size()),   0);

        // Refill, start 1, mask 1010, data valid 1,0,1
        push4(1, 0); push4(3, 0);
        bus4.start_h = 1; bus4.mode_wr_h = 0; bus4.start_adr_h = 1; bus4.wd_req_h = 4'b1010;
        tick();
        bus4.start_h = 0; bus4.wd_req_h = '0;
        check("rf_mem_rq_c1", 32'(bus4.mem_rq_h),     1);
        check("rf_mem_wr_c1", 32'(bus4.mem_wr_h),     0);
        check("rf_hold_c1",   32'(bus4.mb_hold_in_h), 0);
        tick();
        check("rf_mem_rq_c2", 32'(bus4.mem_rq_h), 1);
        bus4.mem_ack_h = 1;
        tick();
        bus4.mem_ack_h = 0; bus4.mem_data_val_h = 1;
        #1;
        check("rf_csh_w1", 32'(bus4.csh_wr_en_h), 32'b0010);
        tick();
        bus4.mem_data_val_h = 0;
        #1;
        check("rf_gap_hold", 32'(bus4.mb_hold_in_h), 0);
        check("rf_gap_csh",  32'(bus4.csh_wr_en_h),  0);
        check("rf_gap_sel",  32'(bus4.mb_sel_h),     1);
        tick();
        bus4.mem_data_val_h = 1;
        #1;
        check("rf_csh_w3", 32'(bus4.csh_wr_en_h), 32'b1000);
        check("rf_done_early", 32'(bus4.done_h), 0);
        tick();
        bus4.mem_data_val_h = 0;
        check("rf_done", 32'(bus4.done_h), 1);
        tick();
        check("rf_busy_end", 32'(bus4.busy_h), 0);
        check("rf_q_empty",  32'(q4.size()),   0);

        // Empty mask
        bus4.start_h = 1; bus4.mode_wr_h = 1; bus4.wd_req_h = '0;
        tick();
        bus4.start_h = 0;
        check("empty_err",  32'(bus4.err_empty_h), 1);
        check("empty_busy", 32'(bus4.busy_h),      0);
        tick();
        check("empty_err_clr", 32'(bus4.err_empty_h), 0);
        check("empty_busy2",   32'(bus4.busy_h),      0);

        // Abort in XFER after one of four words, together with data valid
        push4(0, 0);
        bus4.start_h = 1; bus4.mode_wr_h = 0; bus4.start_adr_h = 0; bus4.wd_req_h = 4'b1111;
        tick();
        bus4.start_h = 0; bus4.wd_req_h = '0;
        bus4.mem_ack_h = 1;
        tick();
        bus4.mem_ack_h = 0; bus4.mem_data_val_h = 1;
        tick();
        bus4.abort_l = 0;
        #1;
        check("ab_hold", 32'(bus4.mb_hold_in_h), 0);
        check("ab_csh",  32'(bus4.csh_wr_en_h),  0);
        check("ab_done", 32'(bus4.done_h),       0);
        tick();
        bus4.abort_l = 1; bus4.mem_data_val_h = 0;
        check("ab_busy",  32'(bus4.busy_h), 0);
        check("ab_done2", 32'(bus4.done_h), 0);
        tick();
        check("ab_done3", 32'(bus4.done_h), 0);
        push4(3, 1);
        bus4.start_h = 1; bus4.mode_wr_h = 1; bus4.start_adr_h = 3; bus4.wd_req_h = 4'b1000;
        tick();
        bus4.start_h = 0; bus4.wd_req_h = '0;
        check("ab_new_busy", 32'(bus4.busy_h),   1);
        check("ab_new_sel",  32'(bus4.mb_sel_h), 3);
        tick();
        check("ab_new_rq", 32'(bus4.mem_rq_h), 1);
        bus4.mem_ack_h = 1;
        tick();
        bus4.mem_ack_h = 0;
        check("ab_new_done", 32'(bus4.done_h), 1);
        tick();
        check("ab_new_idle", 32'(bus4.busy_h), 0);
        check("ab_q_empty",  32'(q4.size()),   0);

        // Reset in LOAD cycle 2; start while busy is ignored
        push4(0, 1);
        bus4.start_h = 1; bus4.mode_wr_h = 1; bus4.start_adr_h = 0; bus4.wd_req_h = 4'b1111;
        tick(); // cycle 1
        bus4.start_h = 1; bus4.mode_wr_h = 0; bus4.start_adr_h = 3; bus4.wd_req_h = 4'b0001;
        check("rl_sel_c1", 32'(bus4.mb_sel_h), 0);
        tick(); // cycle 2
        bus4.start_h = 0; bus4.wd_req_h = '0;
        check("rl_ignore_sel",  32'(bus4.mb_sel_h), 1);
        check("rl_ignore_rq",   32'(bus4.mem_rq_h), 0);
        #1;
        mr_reset_l = 1'b0;
        #1;
        check("rl_busy",   32'(bus4.busy_h),       0);
        check("rl_sel",    32'(bus4.mb_sel_h),     0);
        check("rl_hold",   32'(bus4.mb_hold_in_h), 0);
        check("rl_csh",    32'(bus4.csh_wr_en_h),  0);
        check("rl_mem_rq", 32'(bus4.mem_rq_h),     0);
        check("rl_done",   32'(bus4.done_h),       0);
        tick();
        mr_reset_l = 1'b1;
        push4(1, 1);
        bus4.start_h = 1; bus4.mode_wr_h = 1; bus4.start_adr_h = 1; bus4.wd_req_h = 4'b0010;
        tick();
        bus4.start_h = 0; bus4.wd_req_h = '0;
        check("rl_first_busy", 32'(bus4.busy_h),   1);
        check("rl_first_sel",  32'(bus4.mb_sel_h), 1);
        tick();
        check("rl_first_rq", 32'(bus4.mem_rq_h), 1);
        bus4.mem_ack_h = 1;
        tick();
        bus4.mem_ack_h = 0;
        check("rl_first_done", 32'(bus4.done_h), 1);
        tick();
        check("rl_first_idle", 32'(bus4.busy_h), 0);
        check("rl_q_empty",    32'(q4.size()),   0);

        // NWORDS=8: start 7, mask 10000011 -> 7,0,1 then REQ
        push8(7, 1); push8(0, 1); push8(1, 1);
        bus8.start_h = 1; bus8.mode_wr_h = 1; bus8.start_adr_h = 7; bus8.wd_req_h = 8'b1000_0011;
        tick();
        bus8.start_h = 0; bus8.wd_req_h = '0;
        check("w8_sel_c1", 32'(bus8.mb_sel_h), 7);
        tick();
        check("w8_sel_c2", 32'(bus8.mb_sel_h), 0);
        tick();
        check("w8_sel_c3", 32'(bus8.mb_sel_h), 1);
        tick();
        check("w8_mem_rq", 32'(bus8.mem_rq_h),     1);
        check("w8_hold",   32'(bus8.mb_hold_in_h), 0);
        bus8.mem_ack_h = 1;
        tick();
        bus8.mem_ack_h = 0;
        check("w8_done", 32'(bus8.done_h), 1);
        tick();
        check("w8_idle",    32'(bus8.busy_h), 0);
        check("w8_q_empty", 32'(q8.size()),   0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
